// File: rtl/fir_mac_ctrl.sv
// rtl/fir_mac_ctrl.sv - sequential multiply-accumulate FIR engine, one tap per clock
module fir_mac_ctrl #(
  parameter int NTAPS = 16,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACCW  = DW + CW + $clog2(NTAPS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          st,
  input  logic signed [DW-1:0]          smpl_in,
  output logic [$clog2(NTAPS)-1:0]      coef_addr,
  input  logic signed [CW-1:0]          coef_data,
  output logic                          busy,
  output logic signed [ACCW-1:0]        y,
  output logic                          y_valid,
  output logic                          ovr
);

  localparam int AW = $clog2(NTAPS);
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);

  typedef enum logic {IDLE, MAC} state_t;

  state_t                 state;
  logic signed [DW-1:0]   x [NTAPS];
  logic signed [ACCW-1:0] acc;
  logic [AW-1:0]          idx;

  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0]  prod_ext;
  logic signed [ACCW-1:0]  sum;

  // Operands widened before the multiply so the full signed product is kept.
  assign prod     = (DW+CW)'(x[idx]) * (DW+CW)'(coef_data);
  assign prod_ext = ACCW'(prod);
  assign sum      = acc + prod_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      busy      <= 1'b0;
      ovr       <= 1'b0;
      coef_addr <= '0;
      for (int k = 0; k < NTAPS; k++) x[k] <= '0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (st) begin
            x[0] <= smpl_in;
            for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            acc       <= '0;
            idx       <= '0;
            coef_addr <= '0;
            busy      <= 1'b1;
            state     <= MAC;
          end
        end
        MAC: begin
          // A start during accumulation drops that sample; only the sticky flag records it.
          if (st) ovr <= 1'b1;
          if (idx == LAST) begin
            y         <= sum;
            y_valid   <= 1'b1;
            acc       <= sum;
            idx       <= '0;
            coef_addr <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            acc       <= sum;
            idx       <= idx + 1'b1;
            coef_addr <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// tb/tb_fir_mac_ctrl.sv - directed self-checking bench for fir_mac_ctrl (NTAPS=4)
module tb_fir_mac_ctrl;

  localparam int NTAPS = 4;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int ACCW  = 34;
  localparam int AW    = 2;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   st = 1'b0;
  logic signed [DW-1:0]   smpl_in = '0;
  logic [AW-1:0]          coef_addr;
  logic signed [CW-1:0]   coef_data;
  logic                   busy;
  logic signed [ACCW-1:0] y;
  logic                   y_valid;
  logic                   ovr;

  logic signed [CW-1:0] cmem [NTAPS];
  logic signed [DW-1:0] xm [NTAPS];

  int checks = 0;
  int errors = 0;

  assign coef_data = cmem[coef_addr];

  always #5 clk = ~clk;

  fir_mac_ctrl #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .ACCW(ACCW)) dut (
    .clk(clk), .reset_n(reset_n), .st(st), .smpl_in(smpl_in),
    .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy),
    .y(y), .y_valid(y_valid), .ovr(ovr)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
    cmem[0] = CW'(c0); cmem[1] = CW'(c1); cmem[2] = CW'(c2); cmem[3] = CW'(c3);
  endtask

  // Issue one start, follow the MAC, return in the y_valid cycle.
  task automatic do_sample(input int s, input logic signed [63:0] exp, input string tag);
    int n;
    st = 1'b1; smpl_in = DW'(s);
    tick();
    st = 1'b0;
    n = 1;
    check({tag, "_busy"}, 64'(busy), 1);
    check({tag, "_addr0"}, 64'(coef_addr), 0);
    while (!y_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, NTAPS + 1);
    check({tag, "_y"}, y, exp);
  endtask

  task automatic model_push(input int s, output logic signed [63:0] exp);
    for (int k = NTAPS - 1; k > 0; k--) xm[k] = xm[k-1];
    xm[0] = DW'(s);
    exp = 0;
    for (int k = 0; k < NTAPS; k++) exp = exp + 64'(xm[k]) * 64'(cmem[k]);
  endtask

  initial begin
    int n;
    int vcount;
    logic signed [63:0] e;
    int samples [10];
    samples = '{123, -456, 32767, -32768, 0, 7, -1, 1000, -2000, 31};

    set_coefs(1, 2, 3, 4);
    tick();
    tick();
    check("rst_busy", 64'(busy), 0);
    check("rst_y", y, 0);
    check("rst_yvalid", 64'(y_valid), 0);
    check("rst_ovr", 64'(ovr), 0);
    check("rst_addr", 64'(coef_addr), 0);
    reset_n = 1'b1;
    tick();

    // Impulse response
    do_sample(1, 1, "imp0");
    tick();
    check("imp0_hold_y", y, 1);
    check("imp0_strobe_one", 64'(y_valid), 0);
    do_sample(0, 2, "imp1");
    do_sample(0, 3, "imp2");
    tick();
    do_sample(0, 4, "imp3");
    do_sample(0, 0, "imp4");
    tick();

    // DC
    set_coefs(2, 2, 2, 2);
    do_sample(100, 200, "dc0");
    do_sample(100, 400, "dc1");
    do_sample(100, 600, "dc2");
    do_sample(100, 800, "dc3");
    do_sample(100, 800, "dc4");
    tick();

    // Extremes
    set_coefs(-32768, -32768, -32768, -32768);
    do_sample(-32768, 64'sd1063911424, "ext0");
    do_sample(-32768, 64'sd2140930048, "ext1");
    do_sample(-32768, 64'sd3217948672, "ext2");
    do_sample(-32768, 64'sd4294967296, "ext3");
    tick();
    set_coefs(32767, 32767, 32767, 32767);
    do_sample(-32768, -64'sd4294836224, "mixed");
    tick();

    // Overrun: second start two cycles later is dropped
    set_coefs(1, 2, 3, 4);
    st = 1'b1; smpl_in = 16'sd10;
    tick();
    st = 1'b0;
    tick();
    st = 1'b1; smpl_in = 16'sd99;
    tick();
    st = 1'b0;
    n = 3;
    check("ovr_set", 64'(ovr), 1);
    while (!y_valid && n < 20) begin
      tick();
      n++;
    end
    check("ovr_latency", n, NTAPS + 1);
    check("ovr_y", y, -64'sd294902);
    tick();
    do_sample(0, -64'sd229356, "ovr_next");
    check("ovr_sticky", 64'(ovr), 1);
    tick();

    // Asynchronous reset in MAC cycle 2
    st = 1'b1; smpl_in = 16'sd7;
    tick();
    st = 1'b0;
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 0);
    check("arst_y", y, 0);
    check("arst_yvalid", 64'(y_valid), 0);
    check("arst_ovr", 64'(ovr), 0);
    tick();
    reset_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (y_valid) vcount++;
    end
    check("arst_no_yvalid", vcount, 0);
    set_coefs(3, 2, 3, 4);
    do_sample(5, 15, "arst_after");

    // Back-to-back starts in each y_valid cycle
    set_coefs(1, -2, 3, -4);
    xm[0] = 16'sd5; xm[1] = '0; xm[2] = '0; xm[3] = '0;
    for (int i = 0; i < 10; i++) begin
      model_push(samples[i], e);
      do_sample(samples[i], e, $sformatf("b2b%0d", i));
    end
    tick();
    check("b2b_no_ovr", 64'(ovr), 0);
    check("b2b_idle", 64'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
